// File: rtl/lstm_pkg.sv
// Shared defaults and types for the LSTM sequencer slice.
package lstm_pkg;

  localparam int unsigned LSTM_DATA_WIDTH = 8;
  localparam int unsigned LSTM_LANES      = 4;

  // One step's vector; lane 0 sits in the LSBs.
  typedef logic [LSTM_LANES*LSTM_DATA_WIDTH-1:0] vec_t;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StStart,
    StWait,
    StOut,
    StDone
  } ctrl_state_e;

endpackage

// File: rtl/lstm_edge_det.sv
// Registered rising-edge detector for the core's finished signal.
module lstm_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic sig,
  output logic rise
);

  logic sig_q;

  // Track last cycle's level so a level held high only yields one edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig_q <= 1'b0;
    end else begin
      sig_q <= sig;
    end
  end

  assign rise = sig & ~sig_q;

endmodule

// File: rtl/lstm_seq_ctrl.sv
// lstm_seq_ctrl: runs the LSTM core over a sequence of x vectors, feeding each step's
// result back as the next step's hidden state and streaming every result out.
// Optional feature: define LSTM_SEQ_TIMEOUT_EN for a WAIT watchdog with sticky err flag.
module lstm_seq_ctrl
  import lstm_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = LSTM_DATA_WIDTH,
  parameter int unsigned LANES       = LSTM_LANES,
  parameter int unsigned LEN_W       = 8,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [LEN_W-1:0]            cfg_seq_len,
  input  logic                        seq_go,
  output logic                        busy,
  input  logic                        x_valid,
  output logic                        x_ready,
  input  logic [LANES*DATA_WIDTH-1:0] x_data,
  output logic                        core_start,
  output logic [LANES*DATA_WIDTH-1:0] core_x,
  output logic [LANES*DATA_WIDTH-1:0] core_y_in,
  input  logic                        core_finished,
  input  logic [LANES*DATA_WIDTH-1:0] core_y_out,
  output logic                        y_valid,
  input  logic                        y_ready,
  output logic [LANES*DATA_WIDTH-1:0] y_data,
  output logic                        y_last,
  output logic                        seq_done,
  output logic                        err
);

  localparam int unsigned VecW = LANES * DATA_WIDTH;

  ctrl_state_e     state_q, state_d;
  logic [LEN_W-1:0] len_q, step_q;
  logic [VecW-1:0]  core_x_q, core_y_in_q, y_data_q;
  logic             fin_rise;
  logic             last_step;
  logic             accept_go;
  logic             timeout;

  lstm_edge_det u_fin_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .sig   (core_finished),
    .rise  (fin_rise)
  );

  assign accept_go = (state_q == StIdle) && seq_go;
  // len_q is never 0 while stepping, so the subtraction cannot underflow.
  assign last_step = (step_q == len_q - LEN_W'(1));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (seq_go) state_d = (cfg_seq_len != '0) ? StFetch : StDone;
      StFetch: if (x_valid) state_d = StStart;
      StStart: state_d = StWait;
      StWait: begin
        if (fin_rise) begin
          state_d = StOut;
        end else if (timeout) begin
          state_d = StDone;
        end
      end
      StOut:   if (y_ready) state_d = last_step ? StDone : StFetch;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State-decoded outputs; core_start falls with the async reset of state_q.
  always_comb begin
    busy       = (state_q != StIdle);
    x_ready    = (state_q == StFetch);
    core_start = (state_q == StStart);
    y_valid    = (state_q == StOut);
    y_last     = (state_q == StOut) && last_step;
    seq_done   = (state_q == StDone);
  end

  // Step bookkeeping and vector registers; data passes through bit-exact.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q       <= '0;
      step_q      <= '0;
      core_x_q    <= '0;
      core_y_in_q <= '0;
      y_data_q    <= '0;
    end else begin
      if (accept_go && (cfg_seq_len != '0)) begin
        len_q       <= cfg_seq_len;
        step_q      <= '0;
        core_y_in_q <= '0;
      end
      if ((state_q == StFetch) && x_valid) begin
        core_x_q <= x_data;
      end
      if ((state_q == StWait) && fin_rise) begin
        y_data_q    <= core_y_out;
        core_y_in_q <= core_y_out;
      end
      if ((state_q == StOut) && y_ready && !last_step) begin
        step_q <= step_q + LEN_W'(1);
      end
    end
  end

  assign core_x    = core_x_q;
  assign core_y_in = core_y_in_q;
  assign y_data    = y_data_q;

`ifdef LSTM_SEQ_TIMEOUT_EN
  localparam int unsigned TimerW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

  logic [TimerW-1:0] timer_q;
  logic              err_q;

  // Watchdog: counts cycles spent in WAIT, restarting on every entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer_q <= '0;
    end else if (state_q != StWait) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_q + TimerW'(1);
    end
  end

  assign timeout = (state_q == StWait) && !fin_rise &&
                   (timer_q == TimerW'(TIMEOUT_CYC - 1));

  // Sticky error; only a newly accepted sequence clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (accept_go) begin
      err_q <= 1'b0;
    end else if (timeout) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  logic unused_timeout_cfg;

  assign timeout            = 1'b0;
  assign err                = 1'b0;
  assign unused_timeout_cfg = (TIMEOUT_CYC != 0);
`endif

endmodule
